// File: rtl/spr_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spr_pkg
// Purpose : Shared CPU constants and types for the special-purpose register
//           bank: datapath widths, MODE encodings, SPR indices for
//           move-to/from-SPR decode, and an ECA packing helper.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package spr_pkg;

  localparam int DATA_W    = 32;
  localparam int MCA_W     = 23;
  localparam int ECA_PAD_W = DATA_W - MCA_W;

  // MODE register encodings
  localparam logic MODE_SYS = 1'b0;
  localparam logic MODE_USR = 1'b1;

  // SPR indices used by the move-to/from-SPR instruction decoder
  typedef enum logic [2:0] {
    SPR_SR    = 3'd0,
    SPR_ESR   = 3'd1,
    SPR_ECA   = 3'd2,
    SPR_EPC   = 3'd3,
    SPR_EDATA = 3'd4,
    SPR_PTO   = 3'd5,
    SPR_PTL   = 3'd6,
    SPR_MODE  = 3'd7
  } spr_idx_e;

  // ECA holds the masked cause vector zero-extended to the datapath width
  function automatic logic [DATA_W-1:0] eca_pack(input logic [MCA_W-1:0] mca);
    return {{ECA_PAD_W{1'b0}}, mca};
  endfunction

endpackage : spr_pkg
`default_nettype wire

// File: rtl/spr_reg.sv
`default_nettype none
// ============================================================================
// Module  : spr_reg
// Purpose : Generic W-bit register with asynchronous active-high reset to a
//           parameterised value and a synchronous load enable.
// Ports   : clk   - clock
//           rst   - asynchronous active-high reset
//           i_en  - load enable
//           i_d   - load data
//           o_q   - register output
// Rev     : 1.0  initial release
// ============================================================================
module spr_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= RST_VAL;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule : spr_reg
`default_nettype wire

// File: rtl/spr.sv
`default_nettype none
// ============================================================================
// Module  : spr
// Purpose : Special-purpose register bank (SR, ESR, ECA, EPC, EDATA, PTO, PTL,
//           MODE). On jisr the interrupted context is saved and system mode
//           is entered; otherwise SR/ESR/MODE load from the datapath each
//           cycle. All outputs come straight from registers.
// Ports   : clk, rst          - clock, asynchronous active-high reset
//           jisr              - jump-to-ISR strobe
//           esr, sr, mode     - normal-path write data
//           mca               - masked cause vector
//           rpt               - 1: resume at pc, 0: resume at next_pc
//           pc, next_pc, ea   - interrupted PC, successor PC, fault address
//           sr_out .. mode_out- register outputs
//           pto, ptl          - page table origin / length (constant)
// Rev     : 1.0  initial release
// ============================================================================
module spr
  import spr_pkg::*;
#(
  parameter logic [31:0] PTO_INIT = 32'h0000_0000,
  parameter logic [31:0] PTL_INIT = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jisr,
  input  logic [DATA_W-1:0] esr,
  input  logic [DATA_W-1:0] sr,
  input  logic [MCA_W-1:0]  mca,
  input  logic              rpt,
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] next_pc,
  input  logic [DATA_W-1:0] ea,
  input  logic              mode,
  output logic [DATA_W-1:0] sr_out,
  output logic [DATA_W-1:0] esr_out,
  output logic [DATA_W-1:0] eca_out,
  output logic [DATA_W-1:0] epc_out,
  output logic [DATA_W-1:0] edata_out,
  output logic [DATA_W-1:0] pto,
  output logic [DATA_W-1:0] ptl,
  output logic              mode_out
);

  logic [DATA_W-1:0] w_sr_d;
  logic [DATA_W-1:0] w_esr_d;
  logic [DATA_W-1:0] w_eca_d;
  logic [DATA_W-1:0] w_epc_d;
  logic              w_mode_d;

  // Interrupt entry masks all interrupts and saves the live SR into ESR.
  assign w_sr_d   = jisr ? '0       : sr;
  assign w_esr_d  = jisr ? sr_out   : esr;
  assign w_mode_d = jisr ? MODE_SYS : mode;

  assign w_eca_d  = eca_pack(mca);
  // Only sampled when jisr is high, so an unknown rpt outside interrupt
  // entry never reaches EPC.
  assign w_epc_d  = rpt ? pc : next_pc;

  // SR, ESR and MODE load every cycle (from either path)
  spr_reg #(.W(DATA_W), .RST_VAL('0)) u_sr (
    .clk  (clk),
    .rst  (rst),
    .i_en (1'b1),
    .i_d  (w_sr_d),
    .o_q  (sr_out)
  );

  spr_reg #(.W(DATA_W), .RST_VAL('0)) u_esr (
    .clk  (clk),
    .rst  (rst),
    .i_en (1'b1),
    .i_d  (w_esr_d),
    .o_q  (esr_out)
  );

  spr_reg #(.W(1), .RST_VAL(MODE_SYS)) u_mode (
    .clk  (clk),
    .rst  (rst),
    .i_en (1'b1),
    .i_d  (w_mode_d),
    .o_q  (mode_out)
  );

  // Exception context registers capture only on interrupt entry
  spr_reg #(.W(DATA_W), .RST_VAL('0)) u_eca (
    .clk  (clk),
    .rst  (rst),
    .i_en (jisr),
    .i_d  (w_eca_d),
    .o_q  (eca_out)
  );

  spr_reg #(.W(DATA_W), .RST_VAL('0)) u_epc (
    .clk  (clk),
    .rst  (rst),
    .i_en (jisr),
    .i_d  (w_epc_d),
    .o_q  (epc_out)
  );

  spr_reg #(.W(DATA_W), .RST_VAL('0)) u_edata (
    .clk  (clk),
    .rst  (rst),
    .i_en (jisr),
    .i_d  (ea),
    .o_q  (edata_out)
  );

  // Page table registers have no write path; they sit at their init value.
  spr_reg #(.W(DATA_W), .RST_VAL(PTO_INIT)) u_pto (
    .clk  (clk),
    .rst  (rst),
    .i_en (1'b0),
    .i_d  (PTO_INIT),
    .o_q  (pto)
  );

  spr_reg #(.W(DATA_W), .RST_VAL(PTL_INIT)) u_ptl (
    .clk  (clk),
    .rst  (rst),
    .i_en (1'b0),
    .i_d  (PTL_INIT),
    .o_q  (ptl)
  );

endmodule : spr
`default_nettype wire

// File: tb/tb_spr.sv
`default_nettype none
// ============================================================================
// Module  : tb_spr
// Purpose : Self-checking bench for spr: table of directed vectors applied one
//           clock edge each, plus hand-written asynchronous reset sequences.
// Rev     : 1.0  initial release
// ============================================================================
module tb_spr;

  localparam logic [31:0] C_PTO = 32'h1000_0000;
  localparam logic [31:0] C_PTL = 32'h0000_0400;

  logic        clk;
  logic        rst;
  logic        jisr;
  logic [31:0] esr;
  logic [31:0] sr;
  logic [22:0] mca;
  logic        rpt;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] ea;
  logic        mode;
  logic [31:0] sr_out;
  logic [31:0] esr_out;
  logic [31:0] eca_out;
  logic [31:0] epc_out;
  logic [31:0] edata_out;
  logic [31:0] pto;
  logic [31:0] ptl;
  logic        mode_out;

  int errors = 0;
  int checks = 0;

  spr #(.PTO_INIT(C_PTO), .PTL_INIT(C_PTL)) dut (
    .clk       (clk),
    .rst       (rst),
    .jisr      (jisr),
    .esr       (esr),
    .sr        (sr),
    .mca       (mca),
    .rpt       (rpt),
    .pc        (pc),
    .next_pc   (next_pc),
    .ea        (ea),
    .mode      (mode),
    .sr_out    (sr_out),
    .esr_out   (esr_out),
    .eca_out   (eca_out),
    .epc_out   (epc_out),
    .edata_out (edata_out),
    .pto       (pto),
    .ptl       (ptl),
    .mode_out  (mode_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        jisr;
    logic        rpt;
    logic        mode;
    logic [31:0] sr;
    logic [31:0] esr;
    logic [22:0] mca;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] ea;
    logic [31:0] x_sr;
    logic [31:0] x_esr;
    logic [31:0] x_eca;
    logic [31:0] x_epc;
    logic [31:0] x_edata;
    logic        x_mode;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_sr, input logic [31:0] e_esr,
                           input logic [31:0] e_eca, input logic [31:0] e_epc,
                           input logic [31:0] e_edata, input logic e_mode);
    check({tag, ".sr_out"},    sr_out,             e_sr);
    check({tag, ".esr_out"},   esr_out,            e_esr);
    check({tag, ".eca_out"},   eca_out,            e_eca);
    check({tag, ".epc_out"},   epc_out,            e_epc);
    check({tag, ".edata_out"}, edata_out,          e_edata);
    check({tag, ".mode_out"},  {31'b0, mode_out},  {31'b0, e_mode});
    check({tag, ".pto"},       pto,                C_PTO);
    check({tag, ".ptl"},       ptl,                C_PTL);
  endtask

  task automatic drive(input vec_t v);
    jisr    = v.jisr;
    rpt     = v.rpt;
    mode    = v.mode;
    sr      = v.sr;
    esr     = v.esr;
    mca     = v.mca;
    pc      = v.pc;
    next_pc = v.next_pc;
    ea      = v.ea;
  endtask

  function automatic vec_t mk(input logic j, input logic r, input logic m,
                              input logic [31:0] s, input logic [31:0] e,
                              input logic [22:0] c, input logic [31:0] p,
                              input logic [31:0] n, input logic [31:0] a,
                              input logic [31:0] xs, input logic [31:0] xe,
                              input logic [31:0] xc, input logic [31:0] xp,
                              input logic [31:0] xd, input logic xm);
    vec_t v;
    v.jisr = j; v.rpt = r; v.mode = m; v.sr = s; v.esr = e; v.mca = c;
    v.pc = p; v.next_pc = n; v.ea = a;
    v.x_sr = xs; v.x_esr = xe; v.x_eca = xc; v.x_epc = xp; v.x_edata = xd; v.x_mode = xm;
    return v;
  endfunction

  initial begin
    //            jisr  rpt   mode  sr            esr           mca          pc            next_pc       ea
    //            exp: sr        esr           eca           epc           edata         mode
    // normal load from reset state
    vecs[0] = mk(1'b0, 1'b0, 1'b1, 32'hAAAAAAAA, 32'hCCCCCCCC, 23'h000000, 32'h0F0F0F0F, 32'h00000000, 32'h0000FFFF,
                 32'hAAAAAAAA, 32'hCCCCCCCC, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1);
    // repeat interrupt: ESR takes old SR, sr/esr/mode inputs ignored
    vecs[1] = mk(1'b1, 1'b1, 1'b1, 32'hF0F0F0F0, 32'h12345678, 23'h6AAAAA, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0F0FF0F0,
                 32'h00000000, 32'hAAAAAAAA, 32'h006AAAAA, 32'hF0F0F0F0, 32'h0F0FF0F0, 1'b0);
    // post-interrupt normal: exception context holds
    vecs[2] = mk(1'b0, 1'b1, 1'b1, 32'h55555555, 32'h33333333, 23'h00F0F0, 32'h11111111, 32'h22222222, 32'hFF00FF00,
                 32'h55555555, 32'h33333333, 32'h006AAAAA, 32'hF0F0F0F0, 32'h0F0FF0F0, 1'b1);
    // continue interrupt: EPC takes next_pc
    vecs[3] = mk(1'b1, 1'b0, 1'b1, 32'hF0F0F0F0, 32'h77777777, 23'h6AAAAA, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0F0FF0F0,
                 32'h00000000, 32'h55555555, 32'h006AAAAA, 32'hFF00FF00, 32'h0F0FF0F0, 1'b0);
    // back-to-back interrupt #1: ESR gets the zero SR from the previous entry
    vecs[4] = mk(1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 23'h7FFFFF, 32'h12345678, 32'h9ABCDEF0, 32'hDEADBEEF,
                 32'h00000000, 32'h00000000, 32'h007FFFFF, 32'h12345678, 32'hDEADBEEF, 1'b0);
    // back-to-back interrupt #2
    vecs[5] = mk(1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 23'h000001, 32'h00000001, 32'h00001004, 32'h00000008,
                 32'h00000000, 32'h00000000, 32'h00000001, 32'h00001004, 32'h00000008, 1'b0);
    // normal cycle with rpt unknown: must not disturb held state
    vecs[6] = mk(1'b0, 1'bx, 1'b0, 32'h0F0F0F0F, 32'hF0F0F0F0, 23'h123456, 32'hAAAA0000, 32'hBBBB0000, 32'hCCCC0000,
                 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h00000001, 32'h00001004, 32'h00000008, 1'b0);
    // normal, all-ones SR
    vecs[7] = mk(1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000000, 23'h7FFFFF, 32'h80000000, 32'h80000004, 32'h12121212,
                 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 32'h00001004, 32'h00000008, 1'b1);
    // interrupt from user mode, top MCA bit only
    vecs[8] = mk(1'b1, 1'b1, 1'b1, 32'h13579BDF, 32'h2468ACE0, 23'h400000, 32'h80000000, 32'h80000004, 32'h00000000,
                 32'h00000000, 32'hFFFFFFFF, 32'h00400000, 32'h80000000, 32'h00000000, 1'b1 ^ 1'b1);

    // Reset state
    rst = 1'b1;
    drive(mk(1'b0, 1'b0, 1'b0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", '0, '0, '0, '0, '0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors, one edge each
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].x_sr, vecs[i].x_esr, vecs[i].x_eca,
                vecs[i].x_epc, vecs[i].x_edata, vecs[i].x_mode);
    end

    // Inputs changing between edges must not reach the outputs
    @(negedge clk);
    drive(mk(1'b1, 1'b0, 1'b1, 32'hDEAD0001, 32'hDEAD0002, 23'h0ABCDE, 32'hDEAD0003, 32'hDEAD0004, 32'hDEAD0005,
             '0, '0, '0, '0, '0, 1'b0));
    #2;
    check_all("nocomb", 32'h00000000, 32'hFFFFFFFF, 32'h00400000, 32'h80000000, 32'h00000000, 1'b0);

    // Asynchronous reset mid-cycle, with jisr pending and nonzero state
    rst = 1'b1;
    #1;
    check_all("async_rst", '0, '0, '0, '0, '0, 1'b0);

    // Reset dominates jisr across an active edge
    @(posedge clk);
    #1;
    check_all("rst_over_jisr", '0, '0, '0, '0, '0, 1'b0);

    // Release reset; first normal edge afterwards loads normally
    @(negedge clk);
    rst = 1'b0;
    drive(mk(1'b0, 1'b0, 1'b1, 32'h00000001, 32'h80000000, 23'h7FFFFF, 32'h1, 32'h2, 32'h3,
             '0, '0, '0, '0, '0, 1'b0));
    @(posedge clk);
    #1;
    check_all("after_rst", 32'h00000001, 32'h80000000, '0, '0, '0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_spr
`default_nettype wire
